// File: rtl/seq_restoring_div.sv
// Unsigned restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock,
// out_valid DW edges after accept; result held in DONE until out_ready, no accept while BUSY/DONE.
// DIV_ZERO_FAST_EN: a zero divisor skips BUSY and loads the all-ones result on the accept edge.
module seq_restoring_div #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW + 1);
`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST_ZERO = 1'b1;
`else
   localparam bit FAST_ZERO = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW-1:0] dsr_q;
   logic [VW:0]   prem_q, prem_d;
   logic [CW-1:0] cnt_q;
   logic [VW:0]   prem_sh;
   logic [VW+1:0] trial;
   logic          qbit;

   // One restoring step; the extra MSB of trial is the borrow/sign of the subtract.
   always_comb begin
      prem_sh = {prem_q[VW-1:0], dvd_q[DW-1]};
      trial   = {1'b0, prem_sh} - {2'b00, dsr_q};
      qbit    = ~trial[VW+1];
      prem_d  = qbit ? trial[VW:0] : prem_sh;
      dvd_d   = {dvd_q[DW-2:0], qbit};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         dvd_q       <= '0;
         dsr_q       <= '0;
         prem_q      <= '0;
         cnt_q       <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  dvd_q       <= dividend;
                  dsr_q       <= divisor;
                  prem_q      <= '0;
                  cnt_q       <= CW'(DW);
                  div_by_zero <= (divisor == '0);
                  in_ready    <= 1'b0;
                  if (FAST_ZERO && divisor == '0) begin
                     state_q   <= DONE;
                     out_valid <= 1'b1;
                     quotient  <= '1;
                     remainder <= dividend[VW-1:0];
                  end else begin
                     state_q <= BUSY;
                  end
               end
            end
            BUSY: begin
               prem_q <= prem_d;
               dvd_q  <= dvd_d;
               cnt_q  <= cnt_q - 1'b1;
               // Last iteration: the shift register now holds the full quotient.
               if (cnt_q == CW'(1)) begin
                  state_q   <= DONE;
                  out_valid <= 1'b1;
                  quotient  <= dvd_d;
                  remainder <= prem_d[VW-1:0];
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Bench for seq_restoring_div: directed cases, reset mid-division, and a full operand sweep
// against an arithmetic reference (a/b, a%b, all-ones on a zero divisor).
module tb_seq_restoring_div;

   localparam int DW = 8;
   localparam int VW = 4;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   int total = 0;
   int bad   = 0;

   seq_restoring_div #(.DW(DW), .VW(VW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full transaction; edges are counted after the accept edge (the fast zero path
   // reaches DONE on the accept edge itself, so it expects 0 further edges).
   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input int stall,
                         input bit tie, input bit garble, input bit sweep);
      logic [7:0] eq;
      logic [3:0] er;
      logic       ez;
      int         lat;
      int         w;
      int         el;
      if (b != 4'd0) begin
         eq = a / {4'd0, b};
         er = 4'(a % {4'd0, b});
         ez = 1'b0;
      end else begin
         eq = 8'hFF;
         er = a[3:0];
         ez = 1'b1;
      end
`ifdef DIV_ZERO_FAST_EN
      el = (b == 4'd0) ? 0 : DW;
`else
      el = DW;
`endif
      @(negedge clk);
      out_ready = tie;
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_idle", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (garble) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      chk("latency", 32'(lat), 32'(el));
      chk("quotient", 32'(quotient), 32'(eq));
      chk("remainder", 32'(remainder), 32'(er));
      chk("div_by_zero", 32'(div_by_zero), 32'(ez));
      chk("in_ready_done", 32'(in_ready), 32'd0);
      if (sweep && b != 4'd0) begin
         chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
         chk("rem_lt_div", 32'(remainder < b), 32'd1);
      end
      for (int s = 0; s < stall; s++) begin
         if (garble) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
         end
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_quotient", 32'(quotient), 32'(eq));
         chk("stall_remainder", 32'(remainder), 32'(er));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("handshake_valid", 32'(out_valid), 32'd0);
      chk("handshake_in_ready", 32'(in_ready), 32'd1);
      out_ready = tie;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;

      run_op(8'd200, 4'd7, 0, 1'b0, 1'b0, 1'b0);
      run_op(8'd255, 4'd15, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd3, 4'd9, 0, 1'b1, 1'b0, 1'b0);
      run_op(8'd13, 4'd0, 0, 1'b0, 1'b0, 1'b0);
      run_op(8'd100, 4'd3, 5, 1'b0, 1'b1, 1'b0);

      // Reset three edges into a BUSY 77/5 must clear outputs at once.
      @(negedge clk);
      dividend = 8'd77;
      divisor  = 4'd5;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_quotient", 32'(quotient), 32'd0);
      chk("midrst_remainder", 32'(remainder), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd77, 4'd5, 0, 1'b0, 1'b0, 1'b0);

      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(8'(a), 4'(b), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, 1'b0, 1'b1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
